pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg_if.sv | 40 ++++
 rtl/pipe_stage_reg.sv | 88 ++++++++
 tb/tb_pipe_stage_reg.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready bus for the two-entry pipeline stage register.
// Upstream beat, flush request and downstream beat in one bundle.
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [CTRL_W-1:0]        cntrl_in;
  logic [DATA_W-1:0]        a_in;
  logic [DATA_W-1:0]        b_in;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [CTRL_W+2*DATA_W-1:0] out;

  modport master (
    output in_valid,
    input  in_ready,
    output cntrl_in,
    output a_in,
    output b_in,
    output flush,
    input  out_valid,
    output out_ready,
    input  out
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  cntrl_in,
    input  a_in,
    input  b_in,
    input  flush,
    output out_valid,
    input  out_ready,
    output out
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Two-entry (main + skid) pipeline register, falling-edge clocked,
// with registered ready, flush and a saturating output-stall counter.
module pipe_stage_reg #(
  parameter int CTRL_W  = 3,
  parameter int DATA_W  = 4,
  parameter int STALL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_stage_reg_if.slave    bus,
  output logic [1:0]         occupancy,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam int BEAT_W = CTRL_W + 2 * DATA_W;

  logic [BEAT_W-1:0]  main_q, main_d;
  logic [BEAT_W-1:0]  skid_q, skid_d;
  logic               main_v_q, main_v_d;
  logic               skid_v_q, skid_v_d;
  logic               rdy_q, rdy_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  logic              acc;
  logic              rel;
  logic [BEAT_W-1:0] beat_in;

  assign beat_in = {bus.cntrl_in, bus.a_in, bus.b_in};
  assign acc     = bus.in_valid && rdy_q;
  assign rel     = main_v_q && bus.out_ready;

  // Next-state: move beats between input, main and skid in arrival order.
  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    stall_d  = stall_q;
    if (!rst_n) begin
      main_d   = '0;
      skid_d   = '0;
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      stall_d  = '0;
    end else if (bus.flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else begin
      if (main_v_q && !bus.out_ready && stall_q != '1)
        stall_d = stall_q + STALL_W'(1);
      if (!main_v_q) begin
        if (acc) begin
          main_d   = beat_in;
          main_v_d = 1'b1;
        end
      end else if (!skid_v_q) begin
        if (rel) begin
          if (acc) main_d = beat_in;
          else     main_v_d = 1'b0;
        end else if (acc) begin
          skid_d   = beat_in;
          skid_v_d = 1'b1;
        end
      end else if (rel) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end
    end
    rdy_d = !skid_v_d;
  end

  // State register, updated on the falling edge.
  always_ff @(negedge clk) begin
    main_q   <= main_d;
    skid_q   <= skid_d;
    main_v_q <= main_v_d;
    skid_v_q <= skid_v_d;
    rdy_q    <= rdy_d;
    stall_q  <= stall_d;
  end

  assign bus.out       = main_q;
  assign bus.out_valid = main_v_q;
  assign bus.in_ready  = rdy_q;
  assign occupancy     = {1'b0, main_v_q} + {1'b0, skid_v_q};
  assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: handshake, backpressure,
// flush, stall-counter saturation and reset.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] occupancy;
  logic [1:0] stall_cnt;

  int n_chk = 0;
  int n_fail = 0;

  pipe_stage_reg_if #(.CTRL_W(3), .DATA_W(4)) bus ();

  pipe_stage_reg #(
    .CTRL_W (3),
    .DATA_W (4),
    .STALL_W(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Let the falling edge happen, then sample half a cycle later.
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] c,
                       input logic [3:0] a, input logic [3:0] b);
    bus.in_valid = v;
    bus.cntrl_in = c;
    bus.a_in     = a;
    bus.b_in     = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  localparam logic [10:0] BA = 11'b110_0001_0000;
  localparam logic [10:0] BB = 11'b111_0101_0000;
  localparam logic [10:0] BC = 11'b000_0101_0110;
  localparam logic [10:0] BD = 11'b010_0011_1001;

  initial begin
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 3'b0, 4'b0, 4'b0);

    // reset state
    do_reset();
    check("rst_out",   32'(bus.out), 32'(0));
    check("rst_ovld",  32'(bus.out_valid), 32'(0));
    check("rst_irdy",  32'(bus.in_ready), 32'(1));
    check("rst_occ",   32'(occupancy), 32'(0));
    check("rst_stall", 32'(stall_cnt), 32'(0));

    // single beat
    bus.out_ready = 1'b1;
    drive(1'b1, 3'b110, 4'b0001, 4'b0000);
    tick();
    check("sb_out",  32'(bus.out), 32'(BA));
    check("sb_ovld", 32'(bus.out_valid), 32'(1));
    check("sb_occ",  32'(occupancy), 32'(1));
    drive(1'b0, 3'b0, 4'b0, 4'b0);
    tick();
    check("sb_ovld2", 32'(bus.out_valid), 32'(0));
    check("sb_hold",  32'(bus.out), 32'(BA));
    check("sb_occ2",  32'(occupancy), 32'(0));

    // backpressure
    bus.out_ready = 1'b0;
    drive(1'b1, 3'b110, 4'b0001, 4'b0000);
    tick();
    check("bp_occ1",  32'(occupancy), 32'(1));
    check("bp_irdy1", 32'(bus.in_ready), 32'(1));
    drive(1'b1, 3'b111, 4'b0101, 4'b0000);
    tick();
    check("bp_occ2",  32'(occupancy), 32'(2));
    check("bp_irdy2", 32'(bus.in_ready), 32'(0));
    check("bp_out2",  32'(bus.out), 32'(BA));
    check("bp_st1",   32'(stall_cnt), 32'(1));
    drive(1'b1, 3'b001, 4'b1111, 4'b1111);
    tick();
    check("bp_hold",  32'(bus.out), 32'(BA));
    check("bp_occ3",  32'(occupancy), 32'(2));
    check("bp_st2",   32'(stall_cnt), 32'(2));
    drive(1'b0, 3'b0, 4'b0, 4'b0);
    bus.out_ready = 1'b1;
    tick();
    check("bp_outB",  32'(bus.out), 32'(BB));
    check("bp_irdy3", 32'(bus.in_ready), 32'(1));
    check("bp_occ4",  32'(occupancy), 32'(1));
    tick();
    check("bp_ovld",  32'(bus.out_valid), 32'(0));
    check("bp_occ5",  32'(occupancy), 32'(0));

    // streaming
    do_reset();
    bus.out_ready = 1'b1;
    drive(1'b1, 3'b110, 4'b0001, 4'b0000);
    tick();
    check("st_A",    32'(bus.out), 32'(BA));
    check("st_rdyA", 32'(bus.in_ready), 32'(1));
    drive(1'b1, 3'b111, 4'b0101, 4'b0000);
    tick();
    check("st_B",    32'(bus.out), 32'(BB));
    check("st_rdyB", 32'(bus.in_ready), 32'(1));
    drive(1'b1, 3'b000, 4'b0101, 4'b0110);
    tick();
    check("st_C",    32'(bus.out), 32'(BC));
    check("st_rdyC", 32'(bus.in_ready), 32'(1));
    check("st_occ",  32'(occupancy), 32'(1));
    check("st_stl",  32'(stall_cnt), 32'(0));
    drive(1'b0, 3'b0, 4'b0, 4'b0);
    tick();
    check("st_end",  32'(bus.out_valid), 32'(0));

    // flush with two held beats and a simultaneous accept
    bus.out_ready = 1'b0;
    drive(1'b1, 3'b110, 4'b0001, 4'b0000);
    tick();
    drive(1'b1, 3'b111, 4'b0101, 4'b0000);
    tick();
    check("fl_occ2", 32'(occupancy), 32'(2));
    check("fl_st1",  32'(stall_cnt), 32'(1));
    bus.flush = 1'b1;
    drive(1'b1, 3'b001, 4'b1111, 4'b1010);
    tick();
    bus.flush = 1'b0;
    check("fl_ovld", 32'(bus.out_valid), 32'(0));
    check("fl_occ",  32'(occupancy), 32'(0));
    check("fl_irdy", 32'(bus.in_ready), 32'(1));
    check("fl_out",  32'(bus.out), 32'(BA));
    check("fl_st",   32'(stall_cnt), 32'(1));
    bus.out_ready = 1'b1;
    drive(1'b1, 3'b010, 4'b0011, 4'b1001);
    tick();
    check("fl_newD", 32'(bus.out), 32'(BD));
    check("fl_occ1", 32'(occupancy), 32'(1));
    drive(1'b0, 3'b0, 4'b0, 4'b0);
    tick();
    check("fl_drn",  32'(bus.out_valid), 32'(0));

    // stall counter saturation
    do_reset();
    bus.out_ready = 1'b0;
    drive(1'b1, 3'b110, 4'b0001, 4'b0000);
    tick();
    drive(1'b0, 3'b0, 4'b0, 4'b0);
    check("sat_0", 32'(stall_cnt), 32'(0));
    tick();
    check("sat_1", 32'(stall_cnt), 32'(1));
    tick();
    check("sat_2", 32'(stall_cnt), 32'(2));
    tick();
    check("sat_3", 32'(stall_cnt), 32'(3));
    tick();
    check("sat_4", 32'(stall_cnt), 32'(3));
    tick();
    check("sat_5", 32'(stall_cnt), 32'(3));
    check("sat_out", 32'(bus.out), 32'(BA));

    // reset mid-transfer overrides flush and handshakes
    do_reset();
    bus.out_ready = 1'b0;
    drive(1'b1, 3'b110, 4'b0001, 4'b0000);
    tick();
    drive(1'b1, 3'b111, 4'b0101, 4'b0000);
    tick();
    drive(1'b0, 3'b0, 4'b0, 4'b0);
    tick();
    check("mr_occ",  32'(occupancy), 32'(2));
    check("mr_stl",  32'(stall_cnt), 32'(2));
    rst_n = 1'b0;
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 3'b001, 4'b1111, 4'b1010);
    tick();
    rst_n = 1'b1;
    bus.flush = 1'b0;
    check("mr_out",  32'(bus.out), 32'(0));
    check("mr_ovld", 32'(bus.out_valid), 32'(0));
    check("mr_irdy", 32'(bus.in_ready), 32'(1));
    check("mr_occ0", 32'(occupancy), 32'(0));
    check("mr_stl0", 32'(stall_cnt), 32'(0));
    drive(1'b1, 3'b000, 4'b0101, 4'b0110);
    tick();
    check("mr_C",    32'(bus.out), 32'(BC));
    check("mr_ov1",  32'(bus.out_valid), 32'(1));
    check("mr_oc1",  32'(occupancy), 32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
